// File: rtl/gol_sequencer.sv
// gol_sequencer: paces Game of Life generations, handshakes with
// the update engine, and owns pause state, generation count and cursor.
module gol_sequencer #(
  parameter int GRID_SIZE = 8,
  parameter int TICK_DIV  = 4,
  parameter int GEN_WIDTH = 16,
  localparam int CW = (GRID_SIZE > 1) ? $clog2(GRID_SIZE) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pause,
  input  logic                 moveleft,
  input  logic                 moveright,
  input  logic                 moveup,
  input  logic                 movedown,
  input  logic                 step_done,
  output logic                 step_start,
  output logic                 paused,
  output logic [GEN_WIDTH-1:0] generation,
  output logic                 updatesignal,
  output logic [CW-1:0]        cursor_x,
  output logic [CW-1:0]        cursor_y
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] POS_LAST  = CW'(GRID_SIZE - 1);

  typedef enum logic [1:0] {
    S_WAIT,
    S_START,
    S_BUSY,
    S_PUBLISH
  } state_t;

  state_t state;
  state_t state_next;

  logic [4:0] btn_raw;
  logic [4:0] btn_cur;
  logic [4:0] btn_prev;
  logic [4:0] btn_ev;

  logic                 pend;
  logic                 pend_next;
  logic [TW-1:0]        tick;
  logic [TW-1:0]        tick_d;
  logic [GEN_WIDTH-1:0] gen_d;
  logic                 paused_d;
  logic                 start_d;
  logic                 upd_d;

  // bit order: {down, up, right, left, pause}
  assign btn_raw = {movedown, moveup, moveright, moveleft, pause};

  // edge events are registered so every button acts two edges later
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_cur  <= '0;
      btn_prev <= '0;
      btn_ev   <= '0;
    end else begin
      btn_cur  <= btn_raw;
      btn_prev <= btn_cur;
      btn_ev   <= btn_cur & ~btn_prev;
    end
  end

  assign pend_next = pend ^ btn_ev[0];

  function automatic logic [CW-1:0] step_pos(
    input logic [CW-1:0] p,
    input logic          dec,
    input logic          inc
  );
    logic [CW-1:0] r;
    r = p;
    if (inc && !dec) begin
      r = (p == POS_LAST) ? '0 : p + CW'(1);
    end else if (dec && !inc) begin
      r = (p == '0) ? POS_LAST : p - CW'(1);
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cursor_x <= '0;
      cursor_y <= '0;
    end else if (paused) begin
      cursor_x <= step_pos(cursor_x, btn_ev[1], btn_ev[2]);
      cursor_y <= step_pos(cursor_y, btn_ev[3], btn_ev[4]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_WAIT;
      tick         <= '0;
      pend         <= 1'b0;
      paused       <= 1'b0;
      generation   <= '0;
      step_start   <= 1'b0;
      updatesignal <= 1'b0;
    end else begin
      state        <= state_next;
      tick         <= tick_d;
      pend         <= pend_next;
      paused       <= paused_d;
      generation   <= gen_d;
      step_start   <= start_d;
      updatesignal <= upd_d;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_WAIT: begin
        if (!paused && tick == TICK_LAST) state_next = S_START;
      end
      S_START:   state_next = S_BUSY;
      S_BUSY: begin
        if (step_done) state_next = S_PUBLISH;
      end
      S_PUBLISH: state_next = S_WAIT;
      default:   state_next = S_WAIT;
    endcase
  end

  // a pause request only lands in WAIT so an in-flight step completes
  always_comb begin
    tick_d   = tick;
    gen_d    = generation;
    paused_d = paused;
    start_d  = (state_next == S_START);
    upd_d    = (state_next == S_PUBLISH);
    unique case (state)
      S_WAIT: begin
        paused_d = pend_next;
        if (!paused) begin
          tick_d = (tick == TICK_LAST) ? '0 : tick + TW'(1);
        end
      end
      S_BUSY: begin
        if (step_done) gen_d = generation + GEN_WIDTH'(1);
      end
      S_PUBLISH: begin
        paused_d = pend_next;
        tick_d   = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gol_sequencer.sv
// tb_gol_sequencer: random buttons and engine timing against
// a cycle-level behavioural model of the generation scheduler.
module tb_gol_sequencer;

  localparam int G     = 8;
  localparam int TD    = 4;
  localparam int GW    = 4;
  localparam int CW    = 3;
  localparam int NCYC  = 3000;

  localparam int M_WAIT  = 0;
  localparam int M_START = 1;
  localparam int M_BUSY  = 2;
  localparam int M_PUB   = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          pause, moveleft, moveright, moveup, movedown;
  logic          step_done;
  logic          step_start, paused, updatesignal;
  logic [GW-1:0] generation;
  logic [CW-1:0] cursor_x, cursor_y;

  gol_sequencer #(
    .GRID_SIZE(G),
    .TICK_DIV (TD),
    .GEN_WIDTH(GW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pause       (pause),
    .moveleft    (moveleft),
    .moveright   (moveright),
    .moveup      (moveup),
    .movedown    (movedown),
    .step_done   (step_done),
    .step_start  (step_start),
    .paused      (paused),
    .generation  (generation),
    .updatesignal(updatesignal),
    .cursor_x    (cursor_x),
    .cursor_y    (cursor_y)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int m_mode, m_cnt, m_gen, m_cx, m_cy;
  bit m_pend, m_paused, m_start, m_upd;
  logic [4:0] h [0:3];
  logic [4:0] btn;
  logic [4:0] ev;
  int cd;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    chk("step_start", 32'(step_start), 32'(m_start));
    chk("updatesignal", 32'(updatesignal), 32'(m_upd));
    chk("paused", 32'(paused), 32'(m_paused));
    chk("generation", 32'(generation), 32'(m_gen));
    chk("cursor_x", 32'(cursor_x), 32'(m_cx));
    chk("cursor_y", 32'(cursor_y), 32'(m_cy));
  endtask

  task automatic model_reset();
    m_mode = M_WAIT; m_cnt = 0; m_gen = 0;
    m_cx = 0; m_cy = 0;
    m_pend = 0; m_paused = 0; m_start = 0; m_upd = 0;
    for (int i = 0; i < 4; i++) h[i] = '0;
  endtask

  // a button acts at edge e when it rose at edge e-2
  task automatic model_step();
    bit np, old_paused;
    h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = btn;
    ev = h[2] & ~h[3];
    old_paused = m_paused;
    if (old_paused) begin
      m_cx = (m_cx + G + int'(ev[2]) - int'(ev[1])) % G;
      m_cy = (m_cy + G + int'(ev[4]) - int'(ev[3])) % G;
    end
    np = m_pend ^ ev[0];
    m_pend = np;
    case (m_mode)
      M_WAIT: begin
        m_paused = np;
        if (!old_paused) begin
          if (m_cnt == TD - 1) begin
            m_cnt = 0;
            m_mode = M_START;
          end else m_cnt++;
        end
      end
      M_START: m_mode = M_BUSY;
      M_BUSY: begin
        if (step_done) begin
          m_gen = (m_gen + 1) % (1 << GW);
          m_mode = M_PUB;
        end
      end
      default: begin
        m_paused = np;
        m_cnt = 0;
        m_mode = M_WAIT;
      end
    endcase
    m_start = (m_mode == M_START);
    m_upd   = (m_mode == M_PUB);
  endtask

  task automatic drive();
    if ($urandom_range(0, 24) == 0) btn[0] = ~btn[0];
    for (int i = 1; i < 5; i++)
      if ($urandom_range(0, 3) == 0) btn[i] = ~btn[i];
    {movedown, moveup, moveright, moveleft, pause} = btn;
    if (cd > 0) begin
      step_done = (cd == 1);
      cd--;
    end else begin
      step_done = ($urandom_range(0, 29) == 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    btn = '0;
    {movedown, moveup, moveright, moveleft, pause} = '0;
    step_done = 1'b0;
    cd = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      reset = 1'b0;
      drive();
      if (cyc % 397 == 396) begin
        #2 reset = 1'b1;
        model_reset();
        #1 check_all();
      end
      @(posedge clk);
      if (reset) model_reset();
      else model_step();
      if (m_start) cd = $urandom_range(1, 4) + 1;
      #1 check_all();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gol_sequencer.md
# gol_sequencer

Generation scheduler for the Game of Life machine. It paces generation updates from the system clock, issues a start/done handshake to the grid update engine, and owns the `paused` flag, `generation` count and `updatesignal` strobe that the display logic consumes. It also turns raw user controls into a pause toggle and a wrap-around edit cursor.

## Interface
Parameters:
- `GRID_SIZE`, default 8: grid edge length; cursor coordinates range over 0..GRID_SIZE-1.
- `TICK_DIV`, default 4: clock cycles spent in WAIT between generations; must be ≥1.
- `GEN_WIDTH`, default 16: width of the generation counter.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `pause` in 1: pause button level.
- `moveleft` in 1: cursor-left button level.
- `moveright` in 1: cursor-right button level.
- `moveup` in 1: cursor-up button level.
- `movedown` in 1: cursor-down button level.
- `step_done` in 1: one-cycle pulse from the update engine; grid for the next generation is committed.
- `step_start` out 1: one-cycle pulse commanding the engine to compute one generation.
- `paused` out 1: 1 while generation stepping is suspended.
- `generation` out GEN_WIDTH: completed-generation count.
- `updatesignal` out 1: one-cycle strobe; `generation` and the grid are fresh.
- `cursor_x` out $clog2(GRID_SIZE): edit cursor column.
- `cursor_y` out $clog2(GRID_SIZE): edit cursor row.

## Operation
- Button inputs are registered once, then rising-edge detected: event = current & ~previous. Holding a button produces exactly one event.
- Pause event toggles a pending-pause request bit.
  - In WAIT, the request applies to `paused` on the same edge.
  - In START, BUSY or PUBLISH, it applies on entry to WAIT. An in-flight step is never aborted.
- Cursor moves apply only while `paused`=1. Events while running are discarded.
  - Left: x-1, wrapping 0→GRID_SIZE-1. Right: x+1, wrapping GRID_SIZE-1→0. Up: y-1 with wrap. Down: y+1 with wrap.
  - Left and right in the same cycle cancel. Up and down in the same cycle cancel.
  - X and Y moves in the same cycle both apply.
- FSM states:
  - WAIT: tick counter increments each cycle while `paused`=0; it holds while paused. At count TICK_DIV-1 with `paused`=0, clear the counter and go to START.
  - START: `step_start`=1 for this cycle only; go to BUSY.
  - BUSY: wait for `step_done`. When it arrives, `generation` increments modulo 2^GEN_WIDTH and the FSM goes to PUBLISH.
  - PUBLISH: `updatesignal`=1 for this cycle only; go to WAIT with counter=0.
- `step_done` outside BUSY is ignored. It causes no count change and no strobe.
- Unpausing in WAIT resumes counting from the held counter value. The counter is not reset.

## Timing
- Reset values:
  - FSM=WAIT, counter=0, pending-pause=0.
  - `paused`=0, `generation`=0, `step_start`=0, `updatesignal`=0.
  - `cursor_x`=0, `cursor_y`=0.
  - Button history registers=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Button to effect: a button rising at edge n is registered at n and detected in the following cycle. `paused` or the cursor changes at edge n+2.
- Running cadence, with `step_done` arriving k cycles after `step_start`:
  - Generation period = TICK_DIV + 1 (START) + k (BUSY) + 1 (PUBLISH) cycles.
  - `step_done` high in cycle c gives `generation` incremented and `updatesignal`=1 in cycle c+1.
- `step_start` is never reasserted before `step_done` is received (single outstanding step).
- Reset mid-step (any state): immediate return to reset values. A later stale `step_done` is ignored because the FSM is in WAIT.
- `generation` wraps from 2^GEN_WIDTH-1 to 0 with a normal `updatesignal` strobe.

## Test plan
- Free run, TICK_DIV=4, engine answers `step_done` 2 cycles after `step_start` → `step_start` every 8 cycles; `updatesignal` 1 cycle after each `step_done`; `generation` reads 1, 2, 3 at successive strobes.
- Pause pressed while in BUSY → current step finishes; `generation` increments once and `updatesignal` fires. `paused`=1 on entry to WAIT, then no further `step_start` for 50 cycles. Second press → stepping resumes.
- Paused; right pressed 9 times with GRID_SIZE=8 → `cursor_x`=1. Up pressed once from y=0 → `cursor_y`=7. Left+right together → x unchanged.
- Running (`paused`=0); movedown held for 20 cycles → `cursor_y` stays 0. Pause held high for 20 cycles → exactly one toggle.
- Spurious `step_done` in WAIT → `generation` unchanged, no `updatesignal`. `reset` asserted in BUSY → all outputs 0 immediately; `step_done` one cycle later ignored.
- GEN_WIDTH=4, run 17 steps → `generation` sequence …14, 15, 0, 1 with a strobe at each.
